lsu_dm_ctrl: RTL

Load/store unit placed between the CPU execute stage and the data memory. It converts RISC-V byte/half/word loads and stores (funct3-encoded) into word-granular memory accesses. The memory has a word-wide write enable and a 1-cycle registered read.
- Sub-word loads: byte-lane extraction plus sign/zero extension.
- Sub-word stores: 2-cycle read-modify-write, with a combinational stall to the CPU.
- Misaligned or illegal accesses are flagged and never touch memory.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_align.sv | 37 +++
 rtl/lsu_dm_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and access legality check for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD_WAIT = 2'd1;
    localparam logic [1:0] RMW_READ  = 2'd2;

    // Stores have no unsigned variants, so any store funct3 with bit 2 set is illegal.
    function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                     (we && funct3[2]);
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane extraction for loads and lane merge for sub-word stores
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] dm_q,
    input  logic [15:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = dm_q[{off, 3'b000} +: 8];
        half_v = dm_q[{off[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    rdata = {{24{byte_v[7]}}, byte_v};
            F3_BU:   rdata = {24'h0, byte_v};
            F3_H:    rdata = {{16{half_v[15]}}, half_v};
            F3_HU:   rdata = {16'h0, half_v};
            default: rdata = dm_q;
        endcase
    end

    // Only SB/SH reach the merge path; SW writes straight through without a read.
    always_comb begin
        data = dm_q;
        if (funct3 == F3_H)
            data[{off[1], 4'b0000} +: 16] = wdata;
        else
            data[{off, 3'b000} +: 8] = wdata[7:0];
    end

endmodule

// File: rtl/lsu_dm_ctrl.sv
// rtl/lsu_dm_ctrl.sv - load/store unit: word-granular memory access with sub-word read-modify-write
module lsu_dm_ctrl
    import lsu_pkg::*;
#(
    parameter int MEMORY_BITS = 12,
    parameter int ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] dm_address,
    output logic [31:0]       dm_data,
    output logic              dm_rden,
    output logic              dm_wren,
    input  logic [31:0]       dm_q
);

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [MEMORY_BITS-1:0] addr_q;
    logic [1:0]             off_q;
    logic [2:0]             f3_q;
    logic [15:0]            wdata_q;
    logic                   req_bad;
    logic                   accept;
    logic [31:0]            align_rdata;
    logic [31:0]            align_data;
    logic                   unused_addr_hi;

    assign unused_addr_hi = ^req_addr[ADDR_W-1:MEMORY_BITS+2];

    assign req_bad = access_err(req_we, req_funct3, req_addr[1:0]);
    assign accept  = (state_q == IDLE) && req_valid && !req_bad;

    lsu_align u_align (
        .dm_q   (dm_q),
        .wdata  (wdata_q),
        .off    (off_q),
        .funct3 (f3_q),
        .rdata  (align_rdata),
        .data   (align_data)
    );

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        rsp_valid = 1'b0;
        err       = 1'b0;
        dm_rden   = 1'b0;
        dm_wren   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        err = 1'b1;
                    end else if (!req_we) begin
                        dm_rden = 1'b1;
                        busy    = 1'b1;
                        state_d = LOAD_WAIT;
                    end else if (req_funct3 == F3_W) begin
                        dm_wren = 1'b1;
                    end else begin
                        dm_rden = 1'b1;
                        busy    = 1'b1;
                        state_d = RMW_READ;
                    end
                end
            end
            LOAD_WAIT: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            RMW_READ: begin
                dm_wren = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are held quiet while reset is low so an abandoned RMW never writes.
        if (!reset) begin
            busy      = 1'b0;
            rsp_valid = 1'b0;
            err       = 1'b0;
            dm_rden   = 1'b0;
            dm_wren   = 1'b0;
        end
    end

    assign rsp_rdata  = rsp_valid ? align_rdata : 32'h0;
    assign dm_data    = (state_q == RMW_READ) ? align_data : req_wdata;
    assign dm_address = (state_q == IDLE)
                      ? {{(ADDR_W-MEMORY_BITS){1'b0}}, req_addr[MEMORY_BITS+1:2]}
                      : {{(ADDR_W-MEMORY_BITS){1'b0}}, addr_q};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            off_q   <= 2'b00;
            f3_q    <= 3'b000;
            wdata_q <= 16'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr[MEMORY_BITS+1:2];
                off_q   <= req_addr[1:0];
                f3_q    <= req_funct3;
                wdata_q <= req_wdata[15:0];
            end
        end
    end

endmodule
